led_frame_sequencer: RTL and testbench

LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

---
 rtl/led_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_frame_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sequencer.sv
// Frame sequencer for a WS2812-style LED chain. It fetches 24-bit GRB pixels,
// streams them MSB-first to a bit encoder, then holds the latch/reset gap.
module led_frame_sequencer #(
    parameter int unsigned TRESET_CYCLES = 5000,
    parameter int unsigned PIX_CNT_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PIX_CNT_W-1:0] num_pixels,
    input  logic [23:0]          pix_data,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 bit_out,
    output logic                 bit_valid,
    input  logic                 bit_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    localparam int unsigned PIX_W = 24;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned LAT_W = (TRESET_CYCLES > 1) ? $clog2(TRESET_CYCLES) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(TRESET_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PIX_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [PIX_CNT_W-1:0] num_q, num_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [PIX_W-1:0]     sr_q, sr_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic                 underrun_q, underrun_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            num_q      <= '0;
            pix_cnt_q  <= '0;
            bit_idx_q  <= '0;
            sr_q       <= '0;
            lat_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            pix_cnt_q  <= pix_cnt_d;
            bit_idx_q  <= bit_idx_d;
            sr_q       <= sr_d;
            lat_q      <= lat_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state logic; every path into LATCH arms the gap counter.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        pix_cnt_d  = pix_cnt_q;
        bit_idx_d  = bit_idx_q;
        sr_d       = sr_q;
        lat_d      = lat_q;
        underrun_d = underrun_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d      = num_pixels;
                    pix_cnt_d  = '0;
                    underrun_d = 1'b0;
                    if (num_pixels == '0) begin
                        state_d = LATCH;
                        lat_d   = LAT_LOAD;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = LATCH;
                    lat_d   = LAT_LOAD;
                    sr_d    = '0;
                end else if (pix_valid) begin
                    sr_d      = pix_data;
                    bit_idx_d = IDX_TOP;
                    state_d   = SHIFT;
                end else if (pix_cnt_q != '0) begin
                    underrun_d = 1'b1;
                end
            end
            SHIFT: begin
                // Abort wins over a simultaneous bit acceptance.
                if (abort) begin
                    state_d   = LATCH;
                    lat_d     = LAT_LOAD;
                    sr_d      = '0;
                    bit_idx_d = '0;
                end else if (bit_ready) begin
                    if (bit_idx_q != '0) begin
                        sr_d      = {sr_q[PIX_W-2:0], 1'b0};
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                        if (pix_cnt_d == num_q) begin
                            state_d = LATCH;
                            lat_d   = LAT_LOAD;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            LATCH: begin
                if (lat_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pix_ready = (state_q == FETCH);
    assign bit_valid = (state_q == SHIFT);
    assign bit_out   = (state_q == SHIFT) & sr_q[PIX_W-1];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == LATCH) && (lat_q == '0);
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed scoreboard bench for led_frame_sequencer: expected bits are queued as
// pixels are offered, accepted bits are collected and compared per frame.
module tb_led_frame_sequencer;

    localparam int unsigned TR = 5000;
    localparam int unsigned PW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [PW-1:0] num_pixels;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready;
    logic          busy;
    logic          done;
    logic          underrun;

    led_frame_sequencer #(.TRESET_CYCLES(TR), .PIX_CNT_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_pixels (num_pixels),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int chk_n = 0;
    int err_n = 0;

    logic [23:0] pix_q[$];
    logic        exp_q[$];
    logic        got_q[$];
    logic        pix_hold = 1'b0;
    int          rdy_mode = 0;

    int n_bits = 0, n_done = 0, n_latch = 0, n_pr = 0, n_bv = 0, n_busy = 0, stab_bad = 0;
    int s_bits, s_done, s_latch, s_pr, s_bv, s_busy, s_stab;

    task automatic check(input string tag, input longint obs, input longint exp);
        chk_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pixel source: presents the head of pix_q unless held off.
    initial begin : feeder
        logic take;
        pix_valid = 1'b0;
        pix_data  = 24'h0;
        forever begin
            @(negedge clk);
            take = pix_ready && pix_valid;
            @(posedge clk);
            #2;
            if (take && pix_q.size() > 0) void'(pix_q.pop_front());
            pix_valid = (pix_q.size() > 0) && !pix_hold;
            pix_data  = pix_valid ? pix_q[0] : 24'h0;
        end
    end

    // Encoder model: always ready, or ready one cycle in three.
    initial begin : encoder
        int cyc;
        cyc = 0;
        bit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            bit_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // Observer: collects accepted bits and activity counters.
    logic stalled = 1'b0;
    logic held_bit = 1'b0;
    always @(negedge clk) begin
        if (bit_valid && bit_ready) begin
            got_q.push_back(bit_out);
            n_bits++;
        end
        if (stalled && bit_valid && (bit_out !== held_bit)) stab_bad++;
        stalled  = bit_valid && !bit_ready;
        held_bit = bit_out;
        if (done) n_done++;
        if (busy) n_busy++;
        if (busy && !bit_valid && !pix_ready) n_latch++;
        if (pix_ready) n_pr++;
        if (bit_valid) n_bv++;
    end

    task automatic add_pixel(input logic [23:0] p);
        pix_q.push_back(p);
        for (int i = 23; i >= 0; i--) exp_q.push_back(p[i]);
    endtask

    task automatic snap();
        s_bits = n_bits; s_done = n_done; s_latch = n_latch;
        s_pr = n_pr; s_bv = n_bv; s_busy = n_busy; s_stab = stab_bad;
    endtask

    task automatic pulse_start(input int n);
        num_pixels = PW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_bits(input string tag, input int k);
        int b;
        b = 0;
        while ((n_bits - s_bits) < k && b < 2000) begin
            @(posedge clk); #1;
            b++;
        end
        check({tag, "_bits_reached"}, longint'((n_bits - s_bits) >= k), 1);
    endtask

    task automatic wait_done(input string tag);
        int b;
        b = 0;
        while (n_done == s_done && b < 20000) begin
            @(posedge clk); #1;
            b++;
        end
        check({tag, "_done_seen"}, longint'(n_done > s_done), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_bits(input string tag);
        int i;
        logic g, e;
        i = 0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                check($sformatf("%s_extra_bit%0d", tag, i), 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_bit%0d", tag, i), g, e);
            end
            i++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_bit_out"},   bit_out,   0);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_underrun"},  underrun,  0);
    endtask

    initial begin
        int pr_after;
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_pixels = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Two pixels at full rate, with a start pulse that must be ignored.
        add_pixel(24'hFF0000);
        add_pixel(24'h00A5A5);
        snap();
        pulse_start(2);
        wait_bits("t1", 3);
        pulse_start(2);
        wait_done("t1");
        compare_bits("t1");
        check("t1_exp_left",  exp_q.size(), 0);
        check("t1_nbits",     n_bits - s_bits, 48);
        check("t1_ndone",     n_done - s_done, 1);
        check("t1_latch_len", n_latch - s_latch, TR);
        check("t1_underrun",  underrun, 0);
        snap();
        repeat (20) @(posedge clk);
        #1;
        check("t1_no_second_frame", n_busy - s_busy, 0);

        // One pixel with a stalling encoder.
        rdy_mode = 1;
        add_pixel(24'h5A3C96);
        snap();
        pulse_start(1);
        wait_done("t2");
        compare_bits("t2");
        check("t2_exp_left",  exp_q.size(), 0);
        check("t2_nbits",     n_bits - s_bits, 24);
        check("t2_stable",    stab_bad - s_stab, 0);
        check("t2_stalled",   longint'((n_bv - s_bv) > 24), 1);
        check("t2_ndone",     n_done - s_done, 1);
        check("t2_latch_len", n_latch - s_latch, TR);
        rdy_mode = 0;

        // Pixel 2 withheld: sticky underrun, all bits still delivered.
        add_pixel(24'hC0FFEE);
        snap();
        pulse_start(3);
        wait_bits("t3", 24);
        repeat (10) @(posedge clk);
        #1;
        check("t3_underrun_set", underrun, 1);
        check("t3_waiting",      pix_ready, 1);
        add_pixel(24'h123456);
        add_pixel(24'h0F0F0F);
        wait_done("t3");
        compare_bits("t3");
        check("t3_exp_left",     exp_q.size(), 0);
        check("t3_nbits",        n_bits - s_bits, 72);
        check("t3_underrun_end", underrun, 1);
        check("t3_ndone",        n_done - s_done, 1);

        // Zero-pixel frame; its start clears the sticky underrun.
        snap();
        pulse_start(0);
        check("t4_underrun_clr", underrun, 0);
        check("t4_busy",         busy, 1);
        wait_done("t4");
        check("t4_busy_len", n_busy - s_busy, TR);
        check("t4_pix_ready", n_pr - s_pr, 0);
        check("t4_bit_valid", n_bv - s_bv, 0);
        check("t4_ndone",     n_done - s_done, 1);

        // Abort while bit 5 of the first of four pixels is presented.
        add_pixel(24'hA5F00F);
        add_pixel(24'h111111);
        add_pixel(24'h222222);
        add_pixel(24'h333333);
        snap();
        pulse_start(4);
        wait_bits("t5", 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        pix_q.delete();
        pr_after = n_pr;
        check("t5_latch_bv",   bit_valid, 0);
        check("t5_latch_pr",   pix_ready, 0);
        check("t5_latch_busy", busy, 1);
        wait_done("t5");
        compare_bits("t5");
        check("t5_nbits",     n_bits - s_bits, 6);
        check("t5_latch_len", n_latch - s_latch, TR);
        check("t5_no_pr",     n_pr - pr_after, 0);
        check("t5_ndone",     n_done - s_done, 1);
        exp_q.delete();

        // Reset mid-SHIFT after an ignored start.
        add_pixel(24'hDEADBE);
        add_pixel(24'hEF0123);
        snap();
        pulse_start(2);
        wait_bits("t6", 10);
        pulse_start(1);
        #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        pix_q.delete();
        exp_q.delete();
        got_q.delete();
        snap();
        repeat (30) @(posedge clk);
        #1;
        check("t6_no_done", n_done - s_done, 0);
        check("t6_no_busy", n_busy - s_busy, 0);

        add_pixel(24'h80_0001);
        snap();
        pulse_start(1);
        wait_done("t6b");
        compare_bits("t6b");
        check("t6b_exp_left", exp_q.size(), 0);
        check("t6b_nbits",    n_bits - s_bits, 24);
        check("t6b_ndone",    n_done - s_done, 1);

        $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
        $finish;
    end

endmodule
